pic_ack_ctrl: RTL and testbench
===============================

Name: pic_ack_ctrl

Overview:
- Sequencing controller for the 8259A-style interrupt core. Holds the IRR, IMR, ISR and rotating-priority pointer that feed the priority resolver.
- Runs the two-pulse INTA acknowledge cycle against the CPU and drives the interrupt vector.
- Decodes OCW1/OCW2 writes: mask, EOI, rotation and set-priority.
- Sits between the bus-interface/data-buffer block and the priority resolver.

Parameters:
- SYNC_STAGES, 2, flops in the inta_n synchronizer (minimum 2).
- LEVEL_TRIG, 0, 1 = IRR follows ir_in level; 0 = IRR set on rising edge.
- AEOI, 0, 1 = ISR bit auto-cleared at end of 2nd INTA.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ir_in  in  8  raw interrupt request lines, already synchronous to clk.
- inta_n  in  1  CPU acknowledge strobe, asynchronous, active-low.
- ocw1_we  in  1  one-cycle strobe; write IMR from wdata.
- ocw2_we  in  1  one-cycle strobe; OCW2 command in wdata.
- wdata  in  8  write data.
- vbase  in  5  ICW2 vector base T7..T3.
- pr_intr  in  1  resolver: a request outranks the current service.
- pr_code  in  3  resolver: winning IR level.
- irr  out  8  interrupt request register, to resolver.
- imr  out  8  mask register, to resolver.
- isr  out  8  in-service register, to resolver.
- sp  out  3  lowest-priority level; highest priority is sp+1 mod 8.
- int_o  out  1  interrupt request to CPU.
- dout  out  8  vector output.
- dout_oe  out  1  data-bus drive enable.
- spurious  out  1  one-cycle pulse when an acknowledge finds nothing pending.

Behaviour:
- Reset values (asynchronous): irr=0, imr=8'hFF, isr=0, sp=7, int_o=0, dout=0, dout_oe=0, spurious=0, FSM=IDLE, synchronizer flops=1.
- Edge mode IRR: edge register samples ir_in each cycle; a rising edge sets the irr bit, which stays set until acknowledged.
- Level mode IRR: irr = registered ir_in, except the bit being acknowledged is held 0 for that cycle.
- inta_n passes through SYNC_STAGES flops, then a falling/rising edge detector. Edge pulses are one cycle long, SYNC_STAGES+1 cycles after the pin edge.
- IDLE: int_o <= pr_intr. On INTA fall, go to ACK1.
- ACK1 (entered on 1st fall):
  - Latch code_q <= pr_code.
  - If pr_intr=1: set isr[code_q], clear irr[code_q].
  - If pr_intr=0: raise spurious, set code_q=7, leave isr unchanged.
  - int_o <= 0.
  - Wait for INTA rise, then go to GAP.
- GAP: wait for 2nd INTA fall, then go to ACK2. No timeout.
- ACK2:
  - dout <= {vbase, code_q} and dout_oe <= 1 from the cycle after the fall until the cycle after the rise.
  - On rise: if AEOI and the cycle was not spurious, clear isr[code_q]. Go to IDLE.
- int_o can reassert in IDLE no earlier than one cycle after ACK2 exit.
- OCW2 decode uses wdata[7:5] = R, SL, EOI and L = wdata[2:0]:
  - 001 non-specific EOI: clear the highest-priority set isr bit, scanning from sp+1 upward with wrap. No-op if isr=0.
  - 011 specific EOI: clear isr[L].
  - 101 rotate on non-specific EOI: clear as for 001, then sp <= cleared level.
  - 111 rotate on specific EOI: clear isr[L], then sp <= L.
  - 110 set priority: sp <= L.
  - 000, 010, 100: ignored.
- OCW1: imr <= wdata. It only affects the resolver inputs; an in-progress acknowledge completes.
- Simultaneous set and clear in one cycle: isr_next = (isr & ~clr) | set, so set wins on the same bit. irr follows the same rule: new edge vs. acknowledge clear, set wins.
- A write during ACK1/GAP/ACK2 takes effect immediately; the acknowledge sequence is unaffected.
- Reset mid-acknowledge: dout_oe drops asynchronously, FSM returns to IDLE, all registers take their reset values.

Decomposition:
- Shared package pic_pkg holds:
  - FSM state typedef (IDLE, ACK1, GAP, ACK2).
  - OCW2 command constants.
  - Function that rotates an 8-bit vector by sp and returns the highest-priority set index.
- One natural sub-module: pic_inta_sync, the parameterized synchronizer plus edge detector.

Test Plan:
- Reset, imr=8'hFB, vbase=5'b01000, pulse ir_in[2], pr_intr=1, pr_code=2 -> irr=8'h04, int_o=1; two INTA pulses -> isr=8'h04, irr=0, dout=8'h42 with dout_oe=1 only during the 2nd pulse.
- isr=8'h14, sp=7, OCW2=8'h20 -> isr=8'h10; then OCW2=8'hA0 -> isr=0, sp=4.
- OCW2=8'hC5 -> sp=5; OCW2=8'h63 -> isr[3] cleared, sp unchanged.
- pr_intr falls to 0 between int_o and the 1st INTA -> spurious pulse, vector {vbase,3'b111}, isr unchanged.
- AEOI=1, full acknowledge of IR6 -> isr[6] set after 1st INTA, cleared one cycle after 2nd INTA rise.
- rst_n low during ACK2 -> dout_oe=0 immediately, imr=8'hFF, sp=7, FSM=IDLE.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and helpers for the interrupt acknowledge
// controller.
//   ack_state_e  : acknowledge sequencer states (IDLE, ACK1, GAP, ACK2)
//   OCW2_*       : OCW2 command codes, taken from wdata[7:5] = {R, SL, EOI}
//   highest_pri  : highest-priority set bit of a vector under rotating
//                  priority, where level sp is the lowest priority
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } ack_state_e;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_S_EOI      = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_S_EOI  = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;

  // Scan from sp+1 upward, wrapping, and return the first set level.
  // The result is only meaningful when vec is non-zero.
  function automatic logic [2:0] highest_pri(input logic [7:0] vec,
                                             input logic [2:0] sp);
    logic [2:0] idx;
    logic       found;
    highest_pri = 3'(sp + 3'd1);
    found       = 1'b0;
    for (int i = 1; i < 9; i++) begin
      idx = 3'(sp + i[2:0]);
      if (!found && vec[idx]) begin
        highest_pri = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pic_ack_ctrl_if.sv
// pic_ack_ctrl_if: bundles the CPU-bus, request and resolver signals of the
// acknowledge controller.
//   slave  : the controller (consumes requests/writes, drives registers,
//            int_o and the vector bus)
//   master : the surrounding bus-interface block and priority resolver
interface pic_ack_ctrl_if;
  logic [7:0] ir_in;
  logic       inta_n;
  logic       ocw1_we;
  logic       ocw2_we;
  logic [7:0] wdata;
  logic [4:0] vbase;
  logic       pr_intr;
  logic [2:0] pr_code;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [7:0] isr;
  logic [2:0] sp;
  logic       int_o;
  logic [7:0] dout;
  logic       dout_oe;
  logic       spurious;

  modport slave (
    input  ir_in, inta_n, ocw1_we, ocw2_we, wdata, vbase, pr_intr, pr_code,
    output irr, imr, isr, sp, int_o, dout, dout_oe, spurious
  );

  modport master (
    output ir_in, inta_n, ocw1_we, ocw2_we, wdata, vbase, pr_intr, pr_code,
    input  irr, imr, isr, sp, int_o, dout, dout_oe, spurious
  );
endinterface

// File: rtl/pic_inta_sync.sv
// pic_inta_sync: brings the asynchronous inta_n pin into the clk domain and
// produces one-cycle fall/rise pulses, SYNC_STAGES+1 cycles after the pin
// edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   inta_n     : raw acknowledge strobe (active-low, asynchronous)
//   fall, rise : registered single-cycle edge pulses
module pic_inta_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;
  logic rise_q, rise_d;

  // Flops reset to 1 so that releasing reset with inta_n idle-high
  // never produces a phantom edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inta_n};
    prev_d = sync_q[SYNC_STAGES-1];
    fall_d = prev_q & ~sync_q[SYNC_STAGES-1];
    rise_d = ~prev_q & sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign fall = fall_q;
  assign rise = rise_q;

endmodule

// File: rtl/pic_ack_ctrl.sv
// pic_ack_ctrl: sequencing controller of an 8259A-style interrupt core.
// Holds IRR/IMR/ISR and the rotating-priority pointer, runs the two-pulse
// INTA acknowledge and decodes OCW1/OCW2 writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pic_ack_ctrl_if.slave (requests, CPU writes, INTA, vector
//                bus, resolver inputs and register outputs)
module pic_ack_ctrl
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LEVEL_TRIG  = 0,
  parameter int AEOI        = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  pic_ack_ctrl_if.slave  bus
);

  logic inta_fall, inta_rise;

  pic_inta_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inta_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (bus.inta_n),
    .fall   (inta_fall),
    .rise   (inta_rise)
  );

  ack_state_e state_q, state_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] sp_q, sp_d;
  logic [2:0] code_q, code_d;
  logic       spur_cycle_q, spur_cycle_d;
  logic       int_o_q, int_o_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;
  logic       spurious_q, spurious_d;

  logic [7:0] irr_clr, isr_set, isr_clr;
  logic [2:0] ns_lvl;

  // Acknowledge sequencer, OCW decode and register next-state. Sets and
  // clears are collected as masks so that set wins on a same-cycle clash.
  always_comb begin
    state_d      = state_q;
    imr_d        = imr_q;
    sp_d         = sp_q;
    code_d       = code_q;
    spur_cycle_d = spur_cycle_q;
    int_o_d      = 1'b0;
    dout_d       = dout_q;
    dout_oe_d    = dout_oe_q;
    spurious_d   = 1'b0;
    irr_clr      = '0;
    isr_set      = '0;
    isr_clr      = '0;
    ns_lvl       = highest_pri(isr_q, sp_q);

    case (state_q)
      IDLE: begin
        int_o_d = bus.pr_intr;
        if (inta_fall) begin
          state_d = ACK1;
          int_o_d = 1'b0;
          if (bus.pr_intr) begin
            code_d            = bus.pr_code;
            isr_set[bus.pr_code] = 1'b1;
            irr_clr[bus.pr_code] = 1'b1;
            spur_cycle_d      = 1'b0;
          end else begin
            // Request withdrew before the acknowledge: hand out IR7.
            code_d       = 3'd7;
            spurious_d   = 1'b1;
            spur_cycle_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) state_d = GAP;
      end
      GAP: begin
        if (inta_fall) begin
          state_d   = ACK2;
          dout_d    = {bus.vbase, code_q};
          dout_oe_d = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d   = IDLE;
          dout_d    = '0;
          dout_oe_d = 1'b0;
          if (AEOI != 0 && !spur_cycle_q) isr_clr[code_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.ocw1_we) imr_d = bus.wdata;

    if (bus.ocw2_we) begin
      case (bus.wdata[7:5])
        OCW2_NS_EOI: begin
          if (|isr_q) isr_clr[ns_lvl] = 1'b1;
        end
        OCW2_S_EOI: isr_clr[bus.wdata[2:0]] = 1'b1;
        OCW2_ROT_NS_EOI: begin
          if (|isr_q) begin
            isr_clr[ns_lvl] = 1'b1;
            sp_d            = ns_lvl;
          end
        end
        OCW2_ROT_S_EOI: begin
          isr_clr[bus.wdata[2:0]] = 1'b1;
          sp_d                    = bus.wdata[2:0];
        end
        OCW2_SET_PRI: sp_d = bus.wdata[2:0];
        default: ;
      endcase
    end

    isr_d     = (isr_q & ~isr_clr) | isr_set;
    ir_prev_d = bus.ir_in;
    if (LEVEL_TRIG != 0) irr_d = bus.ir_in & ~irr_clr;
    else                 irr_d = (irr_q & ~irr_clr) | (bus.ir_in & ~ir_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irr_q        <= '0;
      ir_prev_q    <= '0;
      imr_q        <= 8'hFF;
      isr_q        <= '0;
      sp_q         <= 3'd7;
      code_q       <= '0;
      spur_cycle_q <= 1'b0;
      int_o_q      <= 1'b0;
      dout_q       <= '0;
      dout_oe_q    <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      irr_q        <= irr_d;
      ir_prev_q    <= ir_prev_d;
      imr_q        <= imr_d;
      isr_q        <= isr_d;
      sp_q         <= sp_d;
      code_q       <= code_d;
      spur_cycle_q <= spur_cycle_d;
      int_o_q      <= int_o_d;
      dout_q       <= dout_d;
      dout_oe_q    <= dout_oe_d;
      spurious_q   <= spurious_d;
    end
  end

  assign bus.irr      = irr_q;
  assign bus.imr      = imr_q;
  assign bus.isr      = isr_q;
  assign bus.sp       = sp_q;
  assign bus.int_o    = int_o_q;
  assign bus.dout     = dout_q;
  assign bus.dout_oe  = dout_oe_q;
  assign bus.spurious = spurious_q;

endmodule

// File: tb/tb_pic_ack_ctrl.sv
// tb_pic_ack_ctrl: self-checking bench for pic_ack_ctrl. The bench plays the
// CPU and the priority resolver. Vectors expected on the data bus are queued
// when an acknowledge starts and compared when dout_oe rises. A second
// instance with AEOI=1 shares all inputs.
module tb_pic_ack_ctrl;
  import pic_pkg::*;

  localparam int SYNC = 2;

  typedef struct {
    logic [7:0] vec;
    logic       spur;
  } exp_t;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;
  exp_t expQ[$];
  logic [7:0] irrExp;
  logic [7:0] isrExp;
  logic prevOe;
  logic spurSeen;

  pic_ack_ctrl_if bus ();
  pic_ack_ctrl_if bus_a ();

  assign bus_a.ir_in   = bus.ir_in;
  assign bus_a.inta_n  = bus.inta_n;
  assign bus_a.ocw1_we = bus.ocw1_we;
  assign bus_a.ocw2_we = bus.ocw2_we;
  assign bus_a.wdata   = bus.wdata;
  assign bus_a.vbase   = bus.vbase;
  assign bus_a.pr_intr = bus.pr_intr;
  assign bus_a.pr_code = bus.pr_code;

  pic_ack_ctrl #(.SYNC_STAGES(SYNC), .LEVEL_TRIG(0), .AEOI(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pic_ack_ctrl #(.SYNC_STAGES(SYNC), .LEVEL_TRIG(0), .AEOI(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeOcw1(input logic [7:0] v);
    bus.wdata = v; bus.ocw1_we = 1'b1;
    waitCycles(1);
    bus.ocw1_we = 1'b0;
  endtask

  task automatic writeOcw2(input logic [7:0] v);
    bus.wdata = v; bus.ocw2_we = 1'b1;
    waitCycles(1);
    bus.ocw2_we = 1'b0;
  endtask

  task automatic intaPulse(input logic expOe);
    bus.inta_n = 1'b0;
    waitCycles(6);
    checkOutput("dout_oe_in_pulse", bus.dout_oe, expOe);
    bus.inta_n = 1'b1;
    waitCycles(6);
    checkOutput("dout_oe_after_pulse", bus.dout_oe, 1'b0);
  endtask

  // Raise a request on lvl, act as resolver, then run the first INTA pulse.
  // With spur set the resolver withdraws the request before INTA.
  task automatic applyStimulus(input int lvl, input logic spur);
    int n;
    bus.ir_in = 8'h00;
    bus.ir_in[lvl] = 1'b1;
    waitCycles(1);
    bus.ir_in = 8'h00;
    irrExp[lvl] = 1'b1;
    checkOutput("irr_after_request", bus.irr, irrExp);
    bus.pr_intr = 1'b1;
    bus.pr_code = 3'(lvl);
    n = 0;
    while (!bus.int_o && n < 8) begin
      waitCycles(1);
      n++;
    end
    checkOutput("int_o_asserted", bus.int_o, 1'b1);
    if (spur) begin
      bus.pr_intr = 1'b0;
      waitCycles(1);
    end
    expQ.push_back('{vec: {bus.vbase, spur ? 3'd7 : 3'(lvl)}, spur: spur});
    intaPulse(1'b0);
    bus.pr_intr = 1'b0;
    if (!spur) begin
      isrExp[lvl] = 1'b1;
      irrExp[lvl] = 1'b0;
    end
    checkOutput("isr_after_ack1", bus.isr, isrExp);
    checkOutput("irr_after_ack1", bus.irr, irrExp);
    checkOutput("int_o_after_ack1", bus.int_o, 1'b0);
  endtask

  // Scoreboard consumer: one vector per rising dout_oe.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevOe   = 1'b0;
      spurSeen = 1'b0;
    end else begin
      if (bus.spurious) spurSeen = 1'b1;
      if (bus.dout_oe && !prevOe) begin
        checkOutput("sb_has_entry", expQ.size() != 0, 1'b1);
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("vector", bus.dout, e.vec);
          checkOutput("spurious_flag", spurSeen, e.spur);
        end
        spurSeen = 1'b0;
      end
      prevOe = bus.dout_oe;
    end
  end

  initial begin
    int n;
    testCount = 0;
    failCount = 0;
    irrExp = '0;
    isrExp = '0;
    prevOe = 1'b0;
    spurSeen = 1'b0;
    bus.ir_in = '0; bus.inta_n = 1'b1; bus.ocw1_we = 1'b0; bus.ocw2_we = 1'b0;
    bus.wdata = '0; bus.vbase = 5'b01000; bus.pr_intr = 1'b0; bus.pr_code = '0;
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("reset_irr", bus.irr, 8'h00);
    checkOutput("reset_imr", bus.imr, 8'hFF);
    checkOutput("reset_isr", bus.isr, 8'h00);
    checkOutput("reset_sp", bus.sp, 3'd7);
    checkOutput("reset_int_o", bus.int_o, 1'b0);
    checkOutput("reset_dout", bus.dout, 8'h00);
    checkOutput("reset_dout_oe", bus.dout_oe, 1'b0);
    checkOutput("reset_spurious", bus.spurious, 1'b0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] basic acknowledge of IR2");
    writeOcw1(8'hFB);
    checkOutput("imr_write", bus.imr, 8'hFB);
    applyStimulus(2, 1'b0);
    intaPulse(1'b1);
    checkOutput("isr_after_ack2", bus.isr, 8'h04);
    checkOutput("int_o_idle", bus.int_o, 1'b0);

    $display("[TB] non-specific and rotating EOI");
    applyStimulus(4, 1'b0);
    intaPulse(1'b1);
    checkOutput("isr_two_set", bus.isr, 8'h14);
    writeOcw2(8'h20);
    checkOutput("ns_eoi_isr", bus.isr, 8'h10);
    writeOcw2(8'hA0);
    checkOutput("rot_ns_eoi_isr", bus.isr, 8'h00);
    checkOutput("rot_ns_eoi_sp", bus.sp, 3'd4);
    isrExp = '0;

    $display("[TB] set priority, ignored command, specific EOI");
    writeOcw2(8'hC5);
    checkOutput("set_pri_sp", bus.sp, 3'd5);
    writeOcw2(8'hA0);
    checkOutput("rot_ns_eoi_empty_sp", bus.sp, 3'd5);
    applyStimulus(3, 1'b0);
    intaPulse(1'b1);
    writeOcw2(8'h43);
    checkOutput("ignored_cmd_isr", bus.isr, 8'h08);
    checkOutput("ignored_cmd_sp", bus.sp, 3'd5);
    writeOcw2(8'h63);
    checkOutput("s_eoi_isr", bus.isr, 8'h00);
    checkOutput("s_eoi_sp", bus.sp, 3'd5);
    isrExp = '0;

    $display("[TB] wrap-around priority scan");
    applyStimulus(2, 1'b0);
    intaPulse(1'b1);
    applyStimulus(7, 1'b0);
    intaPulse(1'b1);
    writeOcw2(8'h20);
    checkOutput("ns_eoi_wrap_first", bus.isr, 8'h04);
    writeOcw2(8'h20);
    checkOutput("ns_eoi_wrap_second", bus.isr, 8'h00);
    isrExp = '0;

    $display("[TB] spurious acknowledge");
    applyStimulus(1, 1'b1);
    intaPulse(1'b1);
    checkOutput("spur_isr", bus.isr, 8'h00);
    checkOutput("spur_irr", bus.irr, 8'h02);

    $display("[TB] reset during second acknowledge");
    applyStimulus(5, 1'b0);
    bus.inta_n = 1'b0;
    waitCycles(6);
    checkOutput("ack2_dout_oe", bus.dout_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dout_oe", bus.dout_oe, 1'b0);
    checkOutput("rst_mid_imr", bus.imr, 8'hFF);
    checkOutput("rst_mid_sp", bus.sp, 3'd7);
    checkOutput("rst_mid_isr", bus.isr, 8'h00);
    checkOutput("rst_mid_state", dut.state_q, IDLE);
    bus.inta_n = 1'b1;
    waitCycles(2);
    rst_n = 1'b1;
    irrExp = '0;
    isrExp = '0;
    waitCycles(2);

    $display("[TB] automatic EOI");
    writeOcw1(8'h00);
    applyStimulus(6, 1'b0);
    checkOutput("aeoi_isr_after_ack1", bus_a.isr, 8'h40);
    bus.inta_n = 1'b0;
    waitCycles(6);
    checkOutput("aeoi_isr_during_ack2", bus_a.isr, 8'h40);
    bus.inta_n = 1'b1;
    n = 0;
    do begin
      waitCycles(1);
      n++;
    end while (bus_a.isr != 8'h00 && n < 12);
    checkOutput("aeoi_isr_cleared", bus_a.isr, 8'h00);
    checkOutput("aeoi_clear_latency", n, SYNC + 2);
    checkOutput("no_aeoi_isr_kept", bus.isr, 8'h40);
    waitCycles(4);
    checkOutput("final_dout_oe", bus.dout_oe, 1'b0);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
